// File: rtl/draw_snake_if.sv
// Pixel-stream and game-control bundle for draw_snake.
// master: upstream/game side driving the stream; slave: the draw_snake stage.
interface draw_snake_if;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [1:0]  dir_in;
  logic        grow;

  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [4:0]  length;
  logic        collision;

  modport master (
    output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in, dir_in, grow,
    input  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out, length, collision
  );

  modport slave (
    input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in, dir_in, grow,
    output hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out, length, collision
  );
endinterface

// File: rtl/draw_snake.sv
// draw_snake: snake game state on a 64x48 grid of 16x16 cells, composited
// over the background pixel stream with a fixed 2-cycle latency.
// Optional build macro SNAKE_GRID_EN: draws 12'h333 cell grid lines on
// non-snake, non-blank pixels.

// One segment comparator lane: does segment (seg_x,seg_y) sit on cell (x,y)?
module draw_snake_seg_hit (
  input  logic [5:0] seg_x,
  input  logic [5:0] seg_y,
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic       en,
  output logic       hit
);
  assign hit = en && (seg_x == x) && (seg_y == y);
endmodule

module draw_snake #(
  parameter int          MAX_LEN     = 16,
  parameter int          STEP_FRAMES = 8,
  parameter logic [11:0] HEAD_RGB    = 12'h0F0,
  parameter logic [11:0] BODY_RGB    = 12'h080
) (
  input  logic       pclk,
  input  logic       rst,
  draw_snake_if.slave bus
);
  localparam int         FC_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, STEP, CHECK} state_t;

  state_t                        state;
  logic [MAX_LEN-1:0][5:0]       seg_x, seg_y;
  logic [4:0]                    len;
  logic [1:0]                    dir, dir_pending, dir_next;
  logic                          grow_pending, collided, step_req, vsync_q;
  logic [FC_W-1:0]               frame_cnt;
  logic [5:0]                    head_x_next, head_y_next;
  logic [5:0]                    cell_x, cell_y;
  logic [MAX_LEN-1:0]            pix_hit, self_hit;

  // stage-1 registers
  logic [10:0] s1_h, s1_v;
  logic        s1_hs, s1_hb, s1_vs, s1_vb, s1_blank, s1_head, s1_body;
  logic [11:0] s1_rgb;
`ifdef SNAKE_GRID_EN
  logic        s1_grid;
`endif

  assign cell_x = bus.hcount_in[9:4];
  assign cell_y = bus.vcount_in[9:4];

  // Per-segment lanes: pixel-vs-segment for rendering, head-vs-segment for self-collision.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_lane
    localparam logic [4:0] IDX = 5'(i);
    draw_snake_seg_hit u_pix (
      .seg_x(seg_x[i]), .seg_y(seg_y[i]), .x(cell_x), .y(cell_y),
      .en(IDX < len), .hit(pix_hit[i])
    );
    draw_snake_seg_hit u_self (
      .seg_x(seg_x[i]), .seg_y(seg_y[i]), .x(seg_x[0]), .y(seg_y[0]),
      .en((IDX != 5'd0) && (IDX < len)), .hit(self_hit[i])
    );
  end

  // Direction filter (reversals ignored) and next head cell with torus wrap.
  always_comb begin
    dir_next    = ((dir_pending ^ dir) == 2'd2) ? dir : dir_pending;
    head_x_next = seg_x[0];
    head_y_next = seg_y[0];
    case (dir_next)
      2'd0:    head_x_next = seg_x[0] + 6'd1;
      2'd1:    head_y_next = (seg_y[0] == 6'd47) ? 6'd0 : seg_y[0] + 6'd1;
      2'd2:    head_x_next = seg_x[0] - 6'd1;
      default: head_y_next = (seg_y[0] == 6'd0) ? 6'd47 : seg_y[0] - 6'd1;
    endcase
  end

  // Game state: frame tick, input capture and the IDLE/STEP/CHECK sequencer.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= 5'd3;
      dir          <= 2'd0;
      dir_pending  <= 2'd0;
      grow_pending <= 1'b0;
      collided     <= 1'b0;
      step_req     <= 1'b0;
      vsync_q      <= 1'b0;
      frame_cnt    <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < 3) ? 6'(32 - i) : 6'd30;
        seg_y[i] <= 6'd24;
      end
    end else begin
      vsync_q     <= bus.vsync_in;
      dir_pending <= bus.dir_in;
      step_req    <= 1'b0;
      if (bus.vsync_in && !vsync_q) begin
        if (frame_cnt == FC_W'(STEP_FRAMES - 1)) begin
          frame_cnt <= '0;
          step_req  <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (bus.grow) grow_pending <= 1'b1;
      case (state)
        IDLE: if (step_req && !collided) state <= STEP;
        STEP: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= head_x_next;
          seg_y[0] <= head_y_next;
          dir      <= dir_next;
          if (grow_pending && (len < LEN_MAX)) len <= len + 5'd1;
          // a pulse landing on the STEP cycle is kept for the next step
          grow_pending <= bus.grow;
          state        <= CHECK;
        end
        CHECK: begin
          if (|self_hit) collided <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: register timing, background and per-pixel hit flags.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s1_h <= '0; s1_v <= '0; s1_hs <= 1'b0; s1_hb <= 1'b0; s1_vs <= 1'b0; s1_vb <= 1'b0;
      s1_rgb <= '0; s1_blank <= 1'b0; s1_head <= 1'b0; s1_body <= 1'b0;
`ifdef SNAKE_GRID_EN
      s1_grid <= 1'b0;
`endif
    end else begin
      s1_h     <= bus.hcount_in;
      s1_v     <= bus.vcount_in;
      s1_hs    <= bus.hsync_in;
      s1_hb    <= bus.hblnk_in;
      s1_vs    <= bus.vsync_in;
      s1_vb    <= bus.vblnk_in;
      s1_rgb   <= bus.rgb_in;
      s1_blank <= bus.hblnk_in | bus.vblnk_in;
      s1_head  <= pix_hit[0];
      s1_body  <= |pix_hit[MAX_LEN-1:1];
`ifdef SNAKE_GRID_EN
      s1_grid  <= (bus.hcount_in[3:0] == 4'd0) || (bus.vcount_in[3:0] == 4'd0);
`endif
    end
  end

  // Stage 2: composite colour; head wins over body, blank forces black.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bus.hcount_out <= '0; bus.vcount_out <= '0;
      bus.hsync_out  <= 1'b0; bus.hblnk_out <= 1'b0;
      bus.vsync_out  <= 1'b0; bus.vblnk_out <= 1'b0;
      bus.rgb_out    <= '0;
    end else begin
      bus.hcount_out <= s1_h;
      bus.vcount_out <= s1_v;
      bus.hsync_out  <= s1_hs;
      bus.hblnk_out  <= s1_hb;
      bus.vsync_out  <= s1_vs;
      bus.vblnk_out  <= s1_vb;
      if (s1_blank)     bus.rgb_out <= 12'h000;
      else if (s1_head) bus.rgb_out <= HEAD_RGB;
      else if (s1_body) bus.rgb_out <= BODY_RGB;
`ifdef SNAKE_GRID_EN
      else if (s1_grid) bus.rgb_out <= 12'h333;
`endif
      else              bus.rgb_out <= s1_rgb;
    end
  end

  assign bus.length    = len;
  assign bus.collision = collided;
endmodule

// File: tb/tb_draw_snake.sv
// Scoreboard bench for draw_snake: the stimulus process queues expected
// outputs, a monitor process pops and compares them when they emerge.
module tb_draw_snake;
  localparam logic [11:0] HEAD = 12'h0F0;
  localparam logic [11:0] BODY = 12'h080;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  draw_snake_if bus();
  draw_snake #(.MAX_LEN(16), .STEP_FRAMES(8), .HEAD_RGB(HEAD), .BODY_RGB(BODY)) dut (
    .pclk(pclk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string       name;
    logic        full;
    logic [10:0] h, v;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
    logic [4:0]  len;
    logic        col;
  } exp_t;

  exp_t pq[$];
  exp_t sq[$];
  logic probe = 1'b0, sts = 1'b0, fin = 1'b0;
  logic [1:0] vp;
  int checks = 0, failures = 0;

  // tb-side copy of the 2-cycle pipeline valid, cleared with the DUT
  always @(posedge pclk or posedge rst)
    if (rst) vp <= 2'b00;
    else     vp <= {vp[0], probe};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    if (e.full) begin
      cmp({e.name, ".rgb"}, 32'(bus.rgb_out), 32'(e.rgb));
      cmp({e.name, ".timing"},
          {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.hblnk_out, bus.vsync_out, bus.vblnk_out, 6'd0},
          {e.h, e.v, e.hs, e.hb, e.vs, e.vb, 6'd0});
    end
    cmp({e.name, ".length"}, 32'(bus.length), 32'(e.len));
    cmp({e.name, ".collision"}, 32'(bus.collision), 32'(e.col));
  endtask

  // Monitor: compare whenever a probed pixel or a status check is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (vp[1]) begin
        if (pq.size() == 0) begin
          checks++; failures++;
          $display("FAIL pixel_queue: output with no expectation at %0t", $time);
        end else begin
          e = pq.pop_front();
          cmp_all(e);
        end
      end
      if (sts) begin
        if (sq.size() == 0) begin
          checks++; failures++;
          $display("FAIL status_queue: check with no expectation at %0t", $time);
        end else begin
          e = sq.pop_front();
          cmp_all(e);
        end
      end
      if (fin) begin
        cmp("queues_drained", 32'(pq.size() + sq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  function automatic logic [11:0] bgx(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg);
`ifdef SNAKE_GRID_EN
    return (h[3:0] == 4'd0 || v[3:0] == 4'd0) ? 12'h333 : bg;
`else
    return bg;
`endif
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_in();
    bus.hcount_in = 11'd1100; bus.vcount_in = 11'd780;
    bus.hsync_in = 1'b0; bus.hblnk_in = 1'b1;
    bus.vsync_in = 1'b0; bus.vblnk_in = 1'b1;
    bus.rgb_in = 12'h000; probe = 1'b0;
  endtask

  task automatic flush();
    idle_in();
    repeat (3) tick();
  endtask

  task automatic px(input string name, input logic [10:0] h, input logic [10:0] v, input logic hb,
                    input logic [11:0] bg, input logic [11:0] want, input logic [4:0] len, input logic col);
    exp_t e;
    bus.hcount_in = h; bus.vcount_in = v; bus.hsync_in = h[2]; bus.hblnk_in = hb;
    bus.vsync_in = 1'b0; bus.vblnk_in = 1'b0; bus.rgb_in = bg; probe = 1'b1;
    e.name = name; e.full = 1'b1; e.h = h; e.v = v; e.hs = h[2]; e.hb = hb; e.vs = 1'b0; e.vb = 1'b0;
    e.rgb = want; e.len = len; e.col = col;
    pq.push_back(e);
    tick();
  endtask

  // full=1 also expects all stream outputs at zero (reset state)
  task automatic status(input string name, input logic full, input logic [4:0] len, input logic col);
    exp_t e;
    e.name = name; e.full = full; e.h = '0; e.v = '0; e.hs = 1'b0; e.hb = 1'b0; e.vs = 1'b0; e.vb = 1'b0;
    e.rgb = '0; e.len = len; e.col = col;
    sq.push_back(e);
    sts = 1'b1;
    @(negedge pclk);
    #1 sts = 1'b0;
  endtask

  task automatic frame();
    idle_in();
    tick();
    bus.vsync_in = 1'b1;
    repeat (2) tick();
    bus.vsync_in = 1'b0;
    repeat (5) tick();
  endtask

  task automatic step();
    repeat (8) frame();
  endtask

  task automatic grow_pulse();
    bus.grow = 1'b1;
    tick();
    bus.grow = 1'b0;
  endtask

  initial begin
    idle_in();
    bus.dir_in = 2'd0; bus.grow = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    status("reset", 1'b1, 5'd3, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // initial snake: head (32,24), body (31,24),(30,24)
    px("init_head",   11'd512, 11'd384, 1'b0, 12'hABC, HEAD, 5'd3, 1'b0);
    px("init_body1",  11'd496, 11'd384, 1'b0, 12'h123, BODY, 5'd3, 1'b0);
    px("init_body2",  11'd480, 11'd384, 1'b0, 12'h456, BODY, 5'd3, 1'b0);
    px("init_bg",     11'd464, 11'd384, 1'b0, 12'h789, bgx(11'd464, 11'd384, 12'h789), 5'd3, 1'b0);
    px("init_bg_mid", 11'd470, 11'd390, 1'b0, 12'hDEF, 12'hDEF, 5'd3, 1'b0);
    px("blank_head",  11'd512, 11'd384, 1'b1, 12'hABC, 12'h000, 5'd3, 1'b0);
    flush();

    step();
    px("step_head",     11'd528, 11'd384, 1'b0, 12'h111, HEAD, 5'd3, 1'b0);
    px("step_tail",     11'd496, 11'd384, 1'b0, 12'h222, BODY, 5'd3, 1'b0);
    px("step_old_tail", 11'd485, 11'd389, 1'b0, 12'h333, 12'h333, 5'd3, 1'b0);
    flush();

    bus.dir_in = 2'd2;
    step();
    px("rev_head", 11'd544, 11'd384, 1'b0, 12'h444, HEAD, 5'd3, 1'b0);
    px("rev_body", 11'd528, 11'd384, 1'b0, 12'h555, BODY, 5'd3, 1'b0);
    flush();

    bus.dir_in = 2'd0;
    repeat (29) step();
    px("x63_head", 11'd1008, 11'd384, 1'b0, 12'h666, HEAD, 5'd3, 1'b0);
    flush();
    step();
    px("wrapx_head", 11'd0,    11'd384, 1'b0, 12'h777, HEAD, 5'd3, 1'b0);
    px("wrapx_body", 11'd1008, 11'd384, 1'b0, 12'h888, BODY, 5'd3, 1'b0);
    flush();

    bus.dir_in = 2'd3;
    repeat (24) step();
    px("y0_head", 11'd0, 11'd0, 1'b0, 12'h999, HEAD, 5'd3, 1'b0);
    flush();
    step();
    px("wrapy_head", 11'd0, 11'd752, 1'b0, 12'hAAA, HEAD, 5'd3, 1'b0);
    px("wrapy_body", 11'd0, 11'd0,   1'b0, 12'hBBB, BODY, 5'd3, 1'b0);
    flush();

    grow_pulse();
    step();
    status("grow4", 1'b0, 5'd4, 1'b0);
    px("grow4_head", 11'd0, 11'd736, 1'b0, 12'hCCC, HEAD, 5'd4, 1'b0);
    flush();
    repeat (12) begin
      grow_pulse();
      step();
    end
    status("grow16", 1'b0, 5'd16, 1'b0);
    grow_pulse();
    step();
    status("grow_sat", 1'b0, 5'd16, 1'b0);
    px("sat_head", 11'd0, 11'd528, 1'b0, 12'h121, HEAD, 5'd16, 1'b0);
    px("sat_tail", 11'd0, 11'd0,   1'b0, 12'h232, BODY, 5'd16, 1'b0);
    px("sat_past", 11'd5, 11'd21,  1'b0, 12'h343, 12'h343, 5'd16, 1'b0);
    flush();

    // self-collision: length 5, then down, left, up
    rst = 1'b1;
    tick();
    status("rst_len", 1'b0, 5'd3, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    bus.dir_in = 2'd0;
    grow_pulse(); step();
    grow_pulse(); step();
    status("grow5", 1'b0, 5'd5, 1'b0);
    bus.dir_in = 2'd1; step();
    bus.dir_in = 2'd2; step();
    bus.dir_in = 2'd3;
    repeat (7) frame();
    idle_in();
    tick();
    bus.vsync_in = 1'b1;
    repeat (2) tick();
    bus.vsync_in = 1'b0;
    tick();
    status("col_before_check", 1'b0, 5'd5, 1'b0);
    tick();
    status("col_in_check", 1'b0, 5'd5, 1'b1);
    repeat (3) tick();

    repeat (16) frame();
    px("frozen_head",  11'd528, 11'd384, 1'b0, 12'h454, HEAD, 5'd5, 1'b1);
    px("frozen_seg3",  11'd544, 11'd384, 1'b0, 12'h565, BODY, 5'd5, 1'b1);
    px("frozen_seg1",  11'd528, 11'd400, 1'b0, 12'h676, BODY, 5'd5, 1'b1);
    px("frozen_clear", 11'd566, 11'd390, 1'b0, 12'h787, 12'h787, 5'd5, 1'b1);
    flush();
    rst = 1'b1;
    tick();
    status("rst_col", 1'b0, 5'd3, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // asynchronous reset in the middle of an active line
    bus.hcount_in = 11'd300; bus.vcount_in = 11'd200; bus.hsync_in = 1'b1;
    bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0; bus.vsync_in = 1'b0; bus.rgb_in = 12'h5A5;
    repeat (4) tick();
    @(posedge pclk);
    #2 rst = 1'b1;
    status("async_rst", 1'b1, 5'd3, 1'b0);
    rst = 1'b0;
    px("resume_px", 11'd300, 11'd200, 1'b0, 12'h5A5, 12'h5A5, 5'd3, 1'b0);
    idle_in();
    status("resume_latency", 1'b1, 5'd3, 1'b0);
    flush();
    fin = 1'b1;
  end
endmodule
